// File: rtl/link_tx_sched.sv
`timescale 1ns/1ps
// Round-robin scheduler and serializer: one frame-sync pulse followed by 16 data bits,
// MSB first, for each granted requester word on a shared serial link.
module link_tx_sched #(
   parameter int N_REQ = 4,
   parameter int IDW   = 2,
   parameter int GAP   = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   input  logic [N_REQ-1:0]      i_req_vld,
   input  logic [16*N_REQ-1:0]   i_req_data,
   output logic [N_REQ-1:0]      o_req_ack,
   output logic                  o_fs,
   output logic                  o_d,
   output logic                  o_busy,
   output logic [IDW-1:0]        o_grant
);

   typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_SHIFT, ST_GAP} state_t;

   state_t           state, state_nxt;
   logic [IDW-1:0]   ptr, ptr_nxt;
   logic [15:0]      sh, sh_nxt;
   logic [3:0]       bit_cnt, bit_cnt_nxt;
   logic [3:0]       gap_cnt, gap_cnt_nxt;
   logic             fs_nxt, d_nxt, busy_nxt;
   logic [N_REQ-1:0] ack_nxt;
   logic [IDW-1:0]   grant_nxt;

   logic [15:0]      words [N_REQ];
   logic [IDW-1:0]   win;
   logic             found;

   for (genvar k = 0; k < N_REQ; k++) begin : g_words
      assign words[k] = i_req_data[16*k +: 16];
   end

   function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int offs);
      return IDW'((int'(base) + offs) % N_REQ);
   endfunction

   // Search starts just after the last winner, so the previous winner has lowest priority.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         if (!found && i_req_vld[rr_idx(ptr, i)]) begin
            found = 1'b1;
            win   = rr_idx(ptr, i);
         end
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_nxt   = state;
      ptr_nxt     = ptr;
      sh_nxt      = sh;
      bit_cnt_nxt = bit_cnt;
      gap_cnt_nxt = gap_cnt;
      grant_nxt   = o_grant;
      fs_nxt      = 1'b0;
      d_nxt       = 1'b0;
      ack_nxt     = '0;
      case (state)
         ST_IDLE: begin
            if (i_en && found) begin
               state_nxt = ST_SYNC;
               sh_nxt    = words[win];
               ptr_nxt   = win;
               grant_nxt = win;
               fs_nxt    = 1'b1;
               ack_nxt   = N_REQ'(1) << win;
            end
         end
         ST_SYNC: begin
            state_nxt   = ST_SHIFT;
            bit_cnt_nxt = '0;
            d_nxt       = sh[15];
            sh_nxt      = {sh[14:0], 1'b0};
         end
         ST_SHIFT: begin
            if (bit_cnt == 4'd15) begin
               bit_cnt_nxt = '0;
               gap_cnt_nxt = '0;
               state_nxt   = (GAP > 0) ? ST_GAP : ST_IDLE;
            end else begin
               bit_cnt_nxt = bit_cnt + 4'd1;
               d_nxt       = sh[15];
               sh_nxt      = {sh[14:0], 1'b0};
            end
         end
         ST_GAP: begin
            if (gap_cnt == 4'(GAP - 1)) begin
               gap_cnt_nxt = '0;
               state_nxt   = ST_IDLE;
            end else begin
               gap_cnt_nxt = gap_cnt + 4'd1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      busy_nxt = (state_nxt != ST_IDLE);
   end

   // Outputs are registered from the next-state values so they line up with the state they describe.
   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (i_rst) begin
         state     <= ST_IDLE;
         ptr       <= IDW'(N_REQ - 1);
         sh        <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         o_fs      <= 1'b0;
         o_d       <= 1'b0;
         o_busy    <= 1'b0;
         o_req_ack <= '0;
         o_grant   <= '0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         sh        <= sh_nxt;
         bit_cnt   <= bit_cnt_nxt;
         gap_cnt   <= gap_cnt_nxt;
         o_fs      <= fs_nxt;
         o_d       <= d_nxt;
         o_busy    <= busy_nxt;
         o_req_ack <= ack_nxt;
         o_grant   <= grant_nxt;
      end
   end

endmodule

// File: tb/tb_link_tx_sched.sv
`timescale 1ns/1ps
// Scoreboard bench for link_tx_sched: directed cases on a GAP=1 instance plus
// random loopback traffic on GAP=0 and GAP=14 instances.
module tb_link_tx_sched;

   typedef struct packed {
      logic [1:0]  g;
      logic [15:0] w;
   } exp_t;

   logic        i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   logic        i_rst, i_en;
   logic [3:0]  i_req_vld;
   logic [63:0] i_req_data;
   logic [3:0]  o_req_ack;
   logic        o_fs, o_d, o_busy;
   logic [1:0]  o_grant;

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   exp_t        exp_q[$];
   int          fs_cnt = 0;
   int          rx_cnt = 0;
   bit          chk_period = 1'b0;
   bit          mon_active = 1'b0;
   int          mon_bits = 0;
   logic [15:0] mon_word = '0;
   logic [1:0]  mon_grant = '0;
   int          last_fs = -1;
   exp_t        mon_e;
   logic [15:0] t1_w;
   int          fb, rxb;

   link_tx_sched #(.N_REQ(4), .IDW(2), .GAP(1)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (i_en),
      .i_req_vld (i_req_vld),
      .i_req_data(i_req_data),
      .o_req_ack (o_req_ack),
      .o_fs      (o_fs),
      .o_d       (o_d),
      .o_busy    (o_busy),
      .o_grant   (o_grant)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic wait_fs(input int target);
      for (int b = 0; b < 500 && fs_cnt < target; b++) step();
      check("wait_fs", fs_cnt, target);
   endtask

   task automatic wait_rx(input int target);
      for (int b = 0; b < 500 && rx_cnt < target; b++) step();
      check("wait_rx", rx_cnt, target);
   endtask

   task automatic pulse_reset();
      i_rst     = 1'b1;
      i_req_vld = '0;
      i_en      = 1'b1;
      steps(2);
      i_rst     = 1'b0;
   endtask

   always @(posedge i_clk) cyc <= cyc + 1;

   // Receiver model for the directed instance: frame sync, then 16 bits MSB first.
   always @(negedge i_clk) begin
      if (i_rst) begin
         mon_active = 1'b0;
         last_fs    = -1;
      end else begin
         if (o_req_ack != 4'b0 && !o_fs) check("ack_outside_sync", o_req_ack, 0);
         if (o_fs) begin
            check("ack_onehot", o_req_ack, 32'(1) << o_grant);
            if (chk_period && last_fs >= 0) check("fs_period", cyc - last_fs, 19);
            last_fs    = cyc;
            fs_cnt++;
            mon_active = 1'b1;
            mon_bits   = 0;
            mon_grant  = o_grant;
         end else if (mon_active) begin
            mon_word = {mon_word[14:0], o_d};
            mon_bits++;
            if (mon_bits == 16) begin
               mon_active = 1'b0;
               rx_cnt++;
               if (exp_q.size() == 0) begin
                  check("unexpected_frame", exp_q.size(), 1);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("grant", mon_grant, mon_e.g);
                  check("word", mon_word, mon_e.w);
               end
            end
         end
      end
   end

   // Loopback instances with random requesters and a round-robin reference model.
   for (genvar g = 0; g < 2; g++) begin : lb
      localparam int LG = (g == 0) ? 0 : 14;
      logic        rst;
      logic [3:0]  vld, ack, vld_q;
      logic [63:0] data;
      logic        fs, d, busy;
      logic [1:0]  grant;
      logic [15:0] req_q [4][$];
      int          win_q[$];
      int          hold [4] = '{default: 0};
      int          ptr = 3, fs_n = 0, rx_n = 0, sent = 0, last = -1, bits = 0;
      int          lw, lidx, lw2;
      bit          active = 1'b0, done = 1'b0;
      logic [15:0] word = '0, wtmp;

      link_tx_sched #(.N_REQ(4), .IDW(2), .GAP(LG)) dut (
         .i_clk     (i_clk),
         .i_rst     (rst),
         .i_en      (1'b1),
         .i_req_vld (vld),
         .i_req_data(data),
         .o_req_ack (ack),
         .o_fs      (fs),
         .o_d       (d),
         .o_busy    (busy),
         .o_grant   (grant)
      );

      always @(posedge i_clk) vld_q <= vld;

      always @(negedge i_clk) begin
         if (!rst) begin
            if (fs) begin
               lw = -1;
               for (int i = 1; i <= 4; i++) begin
                  lidx = (ptr + i) % 4;
                  if (lw < 0 && vld_q[lidx]) lw = lidx;
               end
               check("lb_req_pending", 32'(vld_q != 4'b0), 1);
               if (lw >= 0) begin
                  check("lb_grant", grant, lw);
                  check("lb_ack", ack, 32'(1) << lw);
                  win_q.push_back(lw);
                  ptr = lw;
               end
               if (last >= 0) check("lb_period_min", 32'((cyc - last) >= 18 + LG), 1);
               last   = cyc;
               fs_n++;
               active = 1'b1;
               bits   = 0;
            end else if (active) begin
               word = {word[14:0], d};
               bits++;
               if (bits == 16) begin
                  active = 1'b0;
                  rx_n++;
                  if (win_q.size() > 0 && req_q[win_q[0]].size() > 0) begin
                     lw2 = win_q.pop_front();
                     check("lb_word", word, req_q[lw2].pop_front());
                  end else begin
                     check("lb_sb_underflow", win_q.size(), 1);
                  end
               end
            end
         end
      end

      initial begin
         rst  = 1'b1;
         vld  = '0;
         data = '0;
         repeat (3) @(posedge i_clk);
         #1;
         rst = 1'b0;
         for (int c = 0; c < 30000 && rx_n < 200; c++) begin
            for (int k = 0; k < 4; k++) begin
               if (vld[k] && ack[k]) begin
                  vld[k]  = 1'b0;
                  hold[k] = int'($urandom_range(0, 12));
               end else if (!vld[k] && sent < 200) begin
                  if (hold[k] == 0) begin
                     wtmp              = 16'($urandom);
                     data[16*k +: 16]  = wtmp;
                     req_q[k].push_back(wtmp);
                     vld[k]            = 1'b1;
                     sent++;
                  end else begin
                     hold[k]--;
                  end
               end
            end
            @(posedge i_clk);
            #1;
         end
         check("lb_rx_count", rx_n, 200);
         check("lb_fs_count", fs_n, 200);
         done = 1'b1;
      end
   end

   initial begin
      i_rst      = 1'b1;
      i_en       = 1'b1;
      i_req_vld  = '0;
      i_req_data = '0;
      steps(3);
      check("rst_fs", o_fs, 0);
      check("rst_d", o_d, 0);
      check("rst_busy", o_busy, 0);
      check("rst_ack", o_req_ack, 0);
      check("rst_grant", o_grant, 0);
      i_rst = 1'b0;
      step();

      // Single word, cycle-exact.
      t1_w               = 16'hA55A;
      i_req_data[15:0]   = t1_w;
      i_req_vld          = 4'b0001;
      exp_q.push_back('{g: 2'd0, w: t1_w});
      step();
      check("t1_fs", o_fs, 1);
      check("t1_ack", o_req_ack, 4'b0001);
      check("t1_busy", o_busy, 1);
      check("t1_grant", o_grant, 0);
      i_req_vld = '0;
      step();
      for (int i = 0; i < 16; i++) begin
         if (i == 0) begin
            check("t1_fs_c2", o_fs, 0);
            check("t1_ack_c2", o_req_ack, 0);
         end
         check("t1_bit", o_d, t1_w[15-i]);
         check("t1_busy_shift", o_busy, 1);
         step();
      end
      check("t1_busy_gap", o_busy, 1);
      check("t1_d_gap", o_d, 0);
      step();
      check("t1_busy_idle", o_busy, 0);
      wait_rx(1);

      // All four requesters continuously valid.
      pulse_reset();
      i_req_data = 64'h0004_0003_0002_0001;
      exp_q.push_back('{g: 2'd0, w: 16'h0001});
      exp_q.push_back('{g: 2'd1, w: 16'h0002});
      exp_q.push_back('{g: 2'd2, w: 16'h0003});
      exp_q.push_back('{g: 2'd3, w: 16'h0004});
      exp_q.push_back('{g: 2'd0, w: 16'h0001});
      exp_q.push_back('{g: 2'd1, w: 16'h0002});
      fb         = fs_cnt;
      rxb        = rx_cnt;
      chk_period = 1'b1;
      i_req_vld  = 4'hF;
      wait_fs(fb + 6);
      i_req_vld  = '0;
      wait_rx(rxb + 6);
      chk_period = 1'b0;

      // Only requesters 1 and 3 valid.
      pulse_reset();
      i_req_data = 64'h3333_EEEE_1111_DDDD;
      exp_q.push_back('{g: 2'd1, w: 16'h1111});
      exp_q.push_back('{g: 2'd3, w: 16'h3333});
      exp_q.push_back('{g: 2'd1, w: 16'h1111});
      exp_q.push_back('{g: 2'd3, w: 16'h3333});
      fb        = fs_cnt;
      rxb       = rx_cnt;
      i_req_vld = 4'b1010;
      wait_fs(fb + 4);
      i_req_vld = '0;
      wait_rx(rxb + 4);

      // Enable dropped mid-frame with requester 2 pending.
      pulse_reset();
      rxb                = rx_cnt;
      i_req_data[31:16]  = 16'h1234;
      i_req_vld          = 4'b0010;
      exp_q.push_back('{g: 2'd1, w: 16'h1234});
      step();
      check("t4_fs", o_fs, 1);
      i_req_vld          = 4'b0100;
      i_req_data[47:32]  = 16'hBEEF;
      exp_q.push_back('{g: 2'd2, w: 16'hBEEF});
      steps(6);
      i_en = 1'b0;
      fb   = fs_cnt;
      steps(40);
      check("t4_no_fs_while_dis", fs_cnt, fb);
      check("t4_frame_done", rx_cnt, rxb + 1);
      i_en = 1'b1;
      step();
      check("t4_fs_reen", o_fs, 1);
      check("t4_grant_reen", o_grant, 2);
      i_req_vld = '0;
      wait_rx(rxb + 2);

      // Reset mid-frame at bit 7, then requesters 2 and 0 together.
      pulse_reset();
      i_req_data[63:48] = 16'hDEAD;
      i_req_vld         = 4'b1000;
      step();
      check("t5_grant3", o_grant, 3);
      i_req_vld = '0;
      steps(8);
      i_rst = 1'b1;
      step();
      check("t5_fs", o_fs, 0);
      check("t5_d", o_d, 0);
      check("t5_busy", o_busy, 0);
      check("t5_ack", o_req_ack, 0);
      i_rst             = 1'b0;
      rxb               = rx_cnt;
      fb                = fs_cnt;
      i_req_data[15:0]  = 16'h0A0A;
      i_req_data[47:32] = 16'h2B2B;
      i_req_vld         = 4'b0101;
      exp_q.push_back('{g: 2'd0, w: 16'h0A0A});
      exp_q.push_back('{g: 2'd2, w: 16'h2B2B});
      step();
      check("t5_fs_after", o_fs, 1);
      check("t5_grant0", o_grant, 0);
      i_req_vld[0] = 1'b0;
      wait_fs(fb + 2);
      i_req_vld[2] = 1'b0;
      wait_rx(rxb + 2);
      steps(5);
      check("exp_q_empty", exp_q.size(), 0);

      for (int i = 0; i < 40000 && !(lb[0].done && lb[1].done); i++) step();
      check("lb_done", {30'd0, lb[1].done, lb[0].done}, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
